// File: rtl/intersection_pkg.sv
// intersection_pkg
// Shared types for the two-way intersection controller:
//   state_e  - controller phase
//   dir_e    - which direction receives the next green after clearance
//   lamp_t   - one signal head (red/yellow/green), with one-hot encodings
//   timer_width() - phase-timer width sized to the longest phase parameter
package intersection_pkg;

    typedef enum logic [2:0] {
        CLR      = 3'd0,
        NS_GRN   = 3'd1,
        NS_YEL   = 3'd2,
        EW_GRN   = 3'd3,
        EW_YEL   = 3'd4,
        PED_WALK = 3'd5
    } state_e;

    typedef enum logic {
        DIR_NS = 1'b0,
        DIR_EW = 1'b1
    } dir_e;

    typedef struct packed {
        logic red;
        logic yellow;
        logic green;
    } lamp_t;

    localparam lamp_t LAMP_RED    = 3'b100;
    localparam lamp_t LAMP_YELLOW = 3'b010;
    localparam lamp_t LAMP_GREEN  = 3'b001;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Wide enough to hold the largest phase length.
    function automatic int timer_width(input int g_min, input int g_max,
                                       input int yel, input int clr,
                                       input int walk);
        int m;
        m = max_int(max_int(max_int(g_min, g_max), max_int(yel, clr)), walk);
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/intersection_if.sv
// intersection_if
// Sensor inputs and lamp outputs of the intersection controller.
//   car_ns, car_ew : vehicle presence levels
//   ped_req        : pedestrian button
//   ped_ack        : one-cycle pulse on entry to the walk phase
//   ns_*/ew_*      : one-hot signal heads per direction
//   walk           : pedestrian walk lamp
// Modports: master = environment (drives sensors), slave = controller.
interface intersection_if;
    logic car_ns;
    logic car_ew;
    logic ped_req;
    logic ped_ack;
    logic ns_red;
    logic ns_yellow;
    logic ns_green;
    logic ew_red;
    logic ew_yellow;
    logic ew_green;
    logic walk;

    modport master (
        output car_ns, car_ew, ped_req,
        input  ped_ack, ns_red, ns_yellow, ns_green,
        input  ew_red, ew_yellow, ew_green, walk
    );

    modport slave (
        input  car_ns, car_ew, ped_req,
        output ped_ack, ns_red, ns_yellow, ns_green,
        output ew_red, ew_yellow, ew_green, walk
    );
endinterface

// File: rtl/intersection_phase_timer.sv
// phase_timer
// Up-counter measuring time spent in the current phase.
//   clk, rst : clock and synchronous active-high reset
//   clr      : restart the count at zero on the next edge (phase entry)
//   limit    : count stops advancing once it reaches this value
//   count    : cycles spent in the current phase (saturating)
//   tc       : terminal count, high while count has reached limit
module phase_timer #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (count_q < limit) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    // The count never passes limit unless limit shrinks on a phase change,
    // and every phase change also clears the count, so >= is safe here.
    assign tc    = (count_q >= limit);

endmodule

// File: rtl/intersection_ctrl.sv
// intersection_ctrl
// Two-way intersection controller: sequences NS and EW signal heads plus a
// pedestrian walk phase. Green time is demand-actuated between GREEN_MIN and
// GREEN_MAX; every change of right-of-way passes through an all-red CLR.
//   clk, rst : clock and synchronous active-high reset
//   bus      : intersection_if.slave - sensors in, lamps and ped_ack out
// All outputs are registered and decoded from the next state, so lamps change
// on the same edge as the state register.
module intersection_ctrl
    import intersection_pkg::*;
#(
    parameter int GREEN_MIN = 3,
    parameter int GREEN_MAX = 6,
    parameter int YELLOW    = 2,
    parameter int CLEAR     = 1,
    parameter int WALK      = 4
) (
    input  logic          clk,
    input  logic          rst,
    intersection_if.slave bus
);

    localparam int TW = timer_width(GREEN_MIN, GREEN_MAX, YELLOW, CLEAR, WALK);

    // Last timer value of each phase (phase of length N runs 0..N-1).
    localparam logic [TW-1:0] T_GMIN  = TW'(GREEN_MIN - 1);
    localparam logic [TW-1:0] T_GMAX  = TW'(GREEN_MAX - 1);
    localparam logic [TW-1:0] T_YEL   = TW'(YELLOW - 1);
    localparam logic [TW-1:0] T_CLR   = TW'(CLEAR - 1);
    localparam logic [TW-1:0] T_WALK  = TW'(WALK - 1);

    state_e        state_q, state_d;
    dir_e          next_dir_q, next_dir_d;
    logic          ped_pending_q, ped_pending_d;
    lamp_t         ns_lamp_q, ns_lamp_d;
    lamp_t         ew_lamp_q, ew_lamp_d;
    logic          walk_q, walk_d;
    logic          ped_ack_q, ped_ack_d;

    logic [TW-1:0] timer;
    logic [TW-1:0] timer_limit;
    logic          timer_tc;
    logic          phase_change;
    logic          enter_walk;
    logic          ns_cross_demand;
    logic          ew_cross_demand;

    // ------------------------------------------------------------------
    // Phase timer: restarts on every state entry, saturates at the last
    // cycle of the current phase (greens saturate at GREEN_MAX-1).
    // ------------------------------------------------------------------
    always_comb begin
        timer_limit = T_CLR;
        case (state_q)
            CLR:      timer_limit = T_CLR;
            NS_GRN:   timer_limit = T_GMAX;
            EW_GRN:   timer_limit = T_GMAX;
            NS_YEL:   timer_limit = T_YEL;
            EW_YEL:   timer_limit = T_YEL;
            PED_WALK: timer_limit = T_WALK;
            default:  timer_limit = T_CLR;
        endcase
    end

    assign phase_change = (state_d != state_q);

    phase_timer #(
        .WIDTH (TW)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clr   (phase_change),
        .limit (timer_limit),
        .count (timer),
        .tc    (timer_tc)
    );

    assign ns_cross_demand = bus.car_ew | ped_pending_q;
    assign ew_cross_demand = bus.car_ns | ped_pending_q;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        next_dir_d = next_dir_q;
        case (state_q)
            CLR: begin
                if (timer_tc) begin
                    if (ped_pending_q) begin
                        state_d = PED_WALK;
                    end else if (next_dir_q == DIR_NS) begin
                        state_d = NS_GRN;
                    end else begin
                        state_d = EW_GRN;
                    end
                end
            end
            NS_GRN: begin
                // Gap-out once min green is served and own traffic is gone;
                // max-out only bounds green while someone else is waiting.
                if (ns_cross_demand &&
                    (((timer >= T_GMIN) && !bus.car_ns) || (timer >= T_GMAX))) begin
                    state_d = NS_YEL;
                end
            end
            NS_YEL: begin
                if (timer_tc) begin
                    state_d    = CLR;
                    next_dir_d = DIR_EW;
                end
            end
            EW_GRN: begin
                if (ew_cross_demand &&
                    (((timer >= T_GMIN) && !bus.car_ew) || (timer >= T_GMAX))) begin
                    state_d = EW_YEL;
                end
            end
            EW_YEL: begin
                if (timer_tc) begin
                    state_d    = CLR;
                    next_dir_d = DIR_NS;
                end
            end
            PED_WALK: begin
                // next_dir is left alone so the interrupted rotation resumes.
                if (timer_tc) begin
                    state_d = CLR;
                end
            end
            default: begin
                state_d = CLR;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Pedestrian request latch. Requests during the walk itself are
    // dropped so a held button cannot chain walk phases forever.
    // ------------------------------------------------------------------
    assign enter_walk = (state_d == PED_WALK) && (state_q != PED_WALK);

    always_comb begin
        ped_pending_d = ped_pending_q;
        if (bus.ped_req && (state_q != PED_WALK)) begin
            ped_pending_d = 1'b1;
        end
        if (enter_walk) begin
            ped_pending_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Output decode from the next state (registered below).
    // ------------------------------------------------------------------
    always_comb begin
        ns_lamp_d = LAMP_RED;
        ew_lamp_d = LAMP_RED;
        walk_d    = 1'b0;
        ped_ack_d = enter_walk;
        case (state_d)
            NS_GRN:   ns_lamp_d = LAMP_GREEN;
            NS_YEL:   ns_lamp_d = LAMP_YELLOW;
            EW_GRN:   ew_lamp_d = LAMP_GREEN;
            EW_YEL:   ew_lamp_d = LAMP_YELLOW;
            PED_WALK: walk_d    = 1'b1;
            default: begin
                ns_lamp_d = LAMP_RED;
                ew_lamp_d = LAMP_RED;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= CLR;
            next_dir_q    <= DIR_NS;
            ped_pending_q <= 1'b0;
            ns_lamp_q     <= LAMP_RED;
            ew_lamp_q     <= LAMP_RED;
            walk_q        <= 1'b0;
            ped_ack_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            next_dir_q    <= next_dir_d;
            ped_pending_q <= ped_pending_d;
            ns_lamp_q     <= ns_lamp_d;
            ew_lamp_q     <= ew_lamp_d;
            walk_q        <= walk_d;
            ped_ack_q     <= ped_ack_d;
        end
    end

    assign bus.ns_red    = ns_lamp_q.red;
    assign bus.ns_yellow = ns_lamp_q.yellow;
    assign bus.ns_green  = ns_lamp_q.green;
    assign bus.ew_red    = ew_lamp_q.red;
    assign bus.ew_yellow = ew_lamp_q.yellow;
    assign bus.ew_green  = ew_lamp_q.green;
    assign bus.walk      = walk_q;
    assign bus.ped_ack   = ped_ack_q;

endmodule

// File: tb/tb_intersection_ctrl.sv
// tb_intersection_ctrl
// Cycle-by-cycle check of intersection_ctrl with default timing parameters.
// Each record of the vector table holds inputs, a run length and the lamp
// phase expected after every edge of that run; ped_ack is expected only on
// the first cycle of a record whose ack flag is set.
module tb_intersection_ctrl;

    typedef enum int {P_CLR, P_NSG, P_NSY, P_EWG, P_EWY, P_WALK} phase_e;

    typedef struct {
        bit     rst;
        bit     cns;
        bit     cew;
        bit     ped;
        int     n;
        phase_e ph;
        bit     ack;
    } vec_t;

    localparam int NV = 36;

    logic clk = 1'b0;
    logic rst = 1'b1;

    intersection_if bus ();

    intersection_ctrl #(
        .GREEN_MIN (3),
        .GREEN_MAX (6),
        .YELLOW    (2),
        .CLEAR     (1),
        .WALK      (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    vec_t       tbl [NV];
    logic [7:0] sb_q [$];
    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;

    // {ns_r, ns_y, ns_g, ew_r, ew_y, ew_g, walk, ped_ack}
    function automatic logic [7:0] expect_bits(input phase_e ph, input bit ack);
        logic [7:0] e;
        case (ph)
            P_CLR:   e = 8'b100_100_0_0;
            P_NSG:   e = 8'b001_100_0_0;
            P_NSY:   e = 8'b010_100_0_0;
            P_EWG:   e = 8'b100_001_0_0;
            P_EWY:   e = 8'b100_010_0_0;
            P_WALK:  e = 8'b100_100_1_0;
            default: e = 8'b000_000_0_0;
        endcase
        e[0] = ack;
        return e;
    endfunction

    function automatic vec_t mk(input bit r, input bit cns, input bit cew,
                                input bit ped, input int n, input phase_e ph,
                                input bit ack);
        vec_t v;
        v.rst = r; v.cns = cns; v.cew = cew; v.ped = ped;
        v.n = n; v.ph = ph; v.ack = ack;
        return v;
    endfunction

    // Drive one cycle of inputs, queue its expectation, clock, then compare.
    task automatic step(input bit r, input bit cns, input bit cew, input bit ped,
                        input phase_e ph, input bit ack, input string tag);
        logic [7:0] got;
        logic [7:0] exp;
        rst         = r;
        bus.car_ns  = cns;
        bus.car_ew  = cew;
        bus.ped_req = ped;
        sb_q.push_back(expect_bits(ph, ack));
        @(posedge clk);
        #1;
        cyc++;
        got = {bus.ns_red, bus.ns_yellow, bus.ns_green,
               bus.ew_red, bus.ew_yellow, bus.ew_green,
               bus.walk, bus.ped_ack};
        exp = sb_q.pop_front();
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d lamps got=%b want=%b", tag, cyc, got, exp);
        end else begin
            $display("ok   %s cycle=%0d lamps=%b", tag, cyc, got);
        end
    endtask

    initial begin
        bus.car_ns  = 1'b0;
        bus.car_ew  = 1'b0;
        bus.ped_req = 1'b0;

        //                 rst   cns   cew   ped    n  phase   ack
        // reset, then idle NS green with no demand
        tbl[0]  = mk(1'b1, 1'b0, 1'b0, 1'b0,  2, P_CLR,  1'b0);
        tbl[1]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 50, P_NSG,  1'b0);
        // EW car while NS green is saturated: immediate gap-out
        tbl[2]  = mk(1'b0, 1'b0, 1'b1, 1'b0,  2, P_NSY,  1'b0);
        tbl[3]  = mk(1'b0, 1'b0, 1'b1, 1'b0,  1, P_CLR,  1'b0);
        tbl[4]  = mk(1'b0, 1'b0, 1'b1, 1'b0,  8, P_EWG,  1'b0);
        tbl[5]  = mk(1'b0, 1'b1, 1'b0, 1'b0,  2, P_EWY,  1'b0);
        tbl[6]  = mk(1'b0, 1'b1, 1'b0, 1'b0,  1, P_CLR,  1'b0);
        // gap-out from fresh NS green entry: 3 green, 2 yellow, 1 clear
        tbl[7]  = mk(1'b0, 1'b0, 1'b1, 1'b0,  3, P_NSG,  1'b0);
        tbl[8]  = mk(1'b0, 1'b0, 1'b1, 1'b0,  2, P_NSY,  1'b0);
        tbl[9]  = mk(1'b0, 1'b0, 1'b1, 1'b0,  1, P_CLR,  1'b0);
        tbl[10] = mk(1'b0, 1'b0, 1'b1, 1'b0,  8, P_EWG,  1'b0);
        // both directions busy: max-out at 6 cycles each way
        tbl[11] = mk(1'b0, 1'b1, 1'b1, 1'b0,  2, P_EWY,  1'b0);
        tbl[12] = mk(1'b0, 1'b1, 1'b1, 1'b0,  1, P_CLR,  1'b0);
        tbl[13] = mk(1'b0, 1'b1, 1'b1, 1'b0,  6, P_NSG,  1'b0);
        tbl[14] = mk(1'b0, 1'b1, 1'b1, 1'b0,  2, P_NSY,  1'b0);
        tbl[15] = mk(1'b0, 1'b1, 1'b1, 1'b0,  1, P_CLR,  1'b0);
        tbl[16] = mk(1'b0, 1'b1, 1'b1, 1'b0,  6, P_EWG,  1'b0);
        tbl[17] = mk(1'b0, 1'b1, 1'b1, 1'b0,  2, P_EWY,  1'b0);
        tbl[18] = mk(1'b0, 1'b1, 1'b1, 1'b0,  1, P_CLR,  1'b0);
        // one-cycle ped request in NS green, no cars
        tbl[19] = mk(1'b0, 1'b0, 1'b0, 1'b0,  1, P_NSG,  1'b0);
        tbl[20] = mk(1'b0, 1'b0, 1'b0, 1'b1,  1, P_NSG,  1'b0);
        tbl[21] = mk(1'b0, 1'b0, 1'b0, 1'b0,  1, P_NSG,  1'b0);
        tbl[22] = mk(1'b0, 1'b0, 1'b0, 1'b0,  2, P_NSY,  1'b0);
        tbl[23] = mk(1'b0, 1'b0, 1'b0, 1'b0,  1, P_CLR,  1'b0);
        tbl[24] = mk(1'b0, 1'b0, 1'b0, 1'b0,  1, P_WALK, 1'b1);
        // button pressed again during walk: must be ignored
        tbl[25] = mk(1'b0, 1'b0, 1'b0, 1'b1,  3, P_WALK, 1'b0);
        tbl[26] = mk(1'b0, 1'b0, 1'b0, 1'b0,  1, P_CLR,  1'b0);
        tbl[27] = mk(1'b0, 1'b0, 1'b0, 1'b0,  8, P_EWG,  1'b0);
        // back to NS, latch a ped request, reset during NS yellow
        tbl[28] = mk(1'b0, 1'b1, 1'b0, 1'b0,  2, P_EWY,  1'b0);
        tbl[29] = mk(1'b0, 1'b1, 1'b0, 1'b0,  1, P_CLR,  1'b0);
        tbl[30] = mk(1'b0, 1'b1, 1'b0, 1'b0,  4, P_NSG,  1'b0);
        tbl[31] = mk(1'b0, 1'b0, 1'b0, 1'b0,  2, P_NSG,  1'b0);
        tbl[32] = mk(1'b0, 1'b0, 1'b0, 1'b1,  1, P_NSG,  1'b0);
        tbl[33] = mk(1'b0, 1'b0, 1'b0, 1'b0,  1, P_NSY,  1'b0);
        tbl[34] = mk(1'b1, 1'b0, 1'b0, 1'b0,  1, P_CLR,  1'b0);
        tbl[35] = mk(1'b0, 1'b0, 1'b0, 1'b0, 10, P_NSG,  1'b0);

        for (int i = 0; i < NV; i++) begin
            for (int k = 0; k < tbl[i].n; k++) begin
                step(tbl[i].rst, tbl[i].cns, tbl[i].cew, tbl[i].ped,
                     tbl[i].ph, (k == 0) ? tbl[i].ack : 1'b0,
                     $sformatf("vec%0d", i));
            end
        end

        // Reset in the middle of a walk: heads stay red, walk drops at once,
        // and the rotation restarts at NS even though EW was due next.
        step(1'b0, 1'b0, 1'b0, 1'b1, P_NSG,  1'b0, "hs_ped_req");
        step(1'b0, 1'b0, 1'b0, 1'b0, P_NSY,  1'b0, "hs_yel0");
        step(1'b0, 1'b0, 1'b0, 1'b0, P_NSY,  1'b0, "hs_yel1");
        step(1'b0, 1'b0, 1'b0, 1'b0, P_CLR,  1'b0, "hs_clr");
        step(1'b0, 1'b0, 1'b0, 1'b0, P_WALK, 1'b1, "hs_walk_ack");
        step(1'b0, 1'b0, 1'b0, 1'b0, P_WALK, 1'b0, "hs_walk1");
        step(1'b1, 1'b0, 1'b0, 1'b0, P_CLR,  1'b0, "hs_rst0");
        step(1'b1, 1'b1, 1'b1, 1'b1, P_CLR,  1'b0, "hs_rst1");
        step(1'b0, 1'b0, 1'b0, 1'b0, P_NSG,  1'b0, "hs_rel_ns");
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, P_NSG, 1'b0, "hs_hold");
        end

        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain left=%0d want=0", sb_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
